// File: rtl/dm_responder.sv
// Data-memory slave for the CPU MEM stage: combinational reads, byte-enabled
// writes at the clock edge, a one-cycle-late write trace and a sticky first-fault capture.
module dm_responder #(
    parameter int          DEPTH  = 4096,
    parameter int          ADDR_W = 12,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        wr_valid,
    output logic [31:0] wr_pc,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [31:0] write_count,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fault_addr
);

    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       offset;
    logic              in_range;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       rd_word;
    logic [31:0]       merged;
    logic              is_write;
    logic              align_ok;
    logic              bad;
    logic              commit;

    logic        wr_valid_q,    wr_valid_d;
    logic [31:0] wr_pc_q,       wr_pc_d;
    logic [31:0] wr_addr_q,     wr_addr_d;
    logic [31:0] wr_data_q,     wr_data_d;
    logic [31:0] write_count_q, write_count_d;
    logic        fault_q,       fault_d;
    logic [31:0] fault_pc_q,    fault_pc_d;
    logic [31:0] fault_addr_q,  fault_addr_d;

    // Unsigned offset compare: addresses below BASE wrap high and land out of range.
    assign offset   = m_data_addr - BASE;
    assign in_range = {1'b0, offset} < SPAN;
    assign idx      = offset[ADDR_W+1:2];
    assign rd_word  = mem_q[idx];
    assign m_data_rdata = in_range ? rd_word : 32'h0;

    always_comb begin
        align_ok = 1'b0;
        case (m_data_byteen)
            4'b1111, 4'b0011, 4'b0001: align_ok = (m_data_addr[1:0] == 2'b00);
            4'b1100, 4'b0100:          align_ok = (m_data_addr[1:0] == 2'b10);
            4'b0010:                   align_ok = (m_data_addr[1:0] == 2'b01);
            4'b1000:                   align_ok = (m_data_addr[1:0] == 2'b11);
            4'b0000:                   align_ok = 1'b1;
            default:                   align_ok = 1'b0;
        endcase
    end

    assign is_write = |m_data_byteen;
    assign bad      = is_write ? (!align_ok || !in_range) : (!in_range && |m_data_addr);
    assign commit   = is_write && !bad;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[8*gi +: 8] = m_data_byteen[gi] ? m_data_wdata[8*gi +: 8]
                                                         : rd_word[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        wr_valid_d    = commit;
        wr_pc_d       = commit ? m_inst_addr : wr_pc_q;
        wr_addr_d     = commit ? {m_data_addr[31:2], 2'b00} : wr_addr_q;
        wr_data_d     = commit ? merged : wr_data_q;
        write_count_d = write_count_q + 32'(commit);
        fault_d       = fault_q | bad;
        fault_pc_d    = (bad && !fault_q) ? m_inst_addr : fault_pc_q;
        fault_addr_d  = (bad && !fault_q) ? m_data_addr : fault_addr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (commit) begin
            mem_q[idx] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_valid_q    <= 1'b0;
            wr_pc_q       <= 32'h0;
            wr_addr_q     <= 32'h0;
            wr_data_q     <= 32'h0;
            write_count_q <= 32'h0;
            fault_q       <= 1'b0;
            fault_pc_q    <= 32'h0;
            fault_addr_q  <= 32'h0;
        end else begin
            wr_valid_q    <= wr_valid_d;
            wr_pc_q       <= wr_pc_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            write_count_q <= write_count_d;
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
            fault_addr_q  <= fault_addr_d;
        end
    end

    assign wr_valid    = wr_valid_q;
    assign wr_pc       = wr_pc_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign write_count = write_count_q;
    assign fault       = fault_q;
    assign fault_pc    = fault_pc_q;
    assign fault_addr  = fault_addr_q;

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder on the CPU data port: the slave side of the m_data_* interface driven by the pipeline's MEM stage.
- Read data is combinational and returned in the same cycle the address is presented. Writes commit at the clock edge under byte enables.
- A registered write-trace record is emitted one cycle after each committed write, for the bench/checker.
- Illegal accesses are flagged with a sticky fault that captures the first offender.

Parameters:
DEPTH, 4096, number of 32-bit words; power of two, 2..65536
ADDR_W, 12, word-index width, equal to log2(DEPTH)
BASE, 32'h0000_0000, byte address of word 0; word-aligned

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
m_data_addr  in  32  byte address of access (read and write)
m_data_wdata  in  32  write data, already lane-replicated by CPU
m_data_byteen  in  4  byte write enables; 4'b0000 = read/idle
m_inst_addr  in  32  PC of the instruction in MEM stage, for trace
m_data_rdata  out  32  read word at m_data_addr (combinational)
wr_valid  out  1  one-cycle pulse: trace record valid
wr_pc  out  32  PC of the traced write
wr_addr  out  32  word-aligned byte address written
wr_data  out  32  full word after merge (new contents)
write_count  out  32  number of committed writes since reset
fault  out  1  sticky illegal-access flag
fault_pc  out  32  PC of first faulting access
fault_addr  out  32  byte address of first faulting access

Behaviour:
- Reset: in the cycle reset is sampled high, all DEPTH words clear to 0. wr_valid, wr_pc, wr_addr, wr_data, write_count, fault, fault_pc and fault_addr all go to 0. Reset overrides any write presented in the same cycle; that write is dropped.
- Index: idx = (m_data_addr - BASE) >> 2, modulo 2^32. The access is in range iff (m_data_addr - BASE) < DEPTH*4, unsigned compare with no wrap-around aliasing.
- Read: m_data_rdata = mem[idx] when in range, else 32'h0. The path is purely combinational and independent of byteen. A read and a write to the same word in the same cycle return the OLD word; the new word is visible from the next cycle.
- Legal byteen patterns and their required addr[1:0]:
  - 1111: addr[1:0]=00
  - 0011: addr[1:0]=00
  - 1100: addr[1:0]=10
  - 0001: addr[1:0]=00
  - 0010: addr[1:0]=01
  - 0100: addr[1:0]=10
  - 1000: addr[1:0]=11
  - 0000: any address
- Write commit: at the rising edge, when byteen!=0, the pattern is legal and the address is in range. For each lane k with byteen[k]=1, mem[idx][8k+7:8k] <= m_data_wdata[8k+7:8k]; lanes with byteen[k]=0 are unchanged.
- Trace: the cycle after a commit, wr_valid=1, wr_pc=m_inst_addr, wr_addr={m_data_addr[31:2],2'b00}, wr_data=merged word. Otherwise wr_valid=0 and the other trace fields hold their last values. Back-to-back writes give consecutive pulses, one per write, none dropped.
- write_count increments by 1 per commit and wraps from 2^32-1 to 0.
- Fault: raised by a non-zero byteen with an illegal pattern, a misaligned address, or an out-of-range address. A read (byteen=0) that is out of range also faults, but only when a nonzero address is presented.
  - On the first fault, fault<=1 at the next edge and fault_pc/fault_addr capture that access.
  - Later faults do not update the captured fields; the flag stays set until reset.
  - A faulting write never modifies memory and produces no trace record.
- No handshake and no backpressure: the responder accepts one access per cycle, every cycle.

Test Plan:
- Reset, then byteen=1111, addr=BASE+0x10, wdata=32'hDEADBEEF, pc=32'h3000 -> same-cycle rdata=0. Next cycle: rdata=DEADBEEF, wr_valid=1, wr_addr=0x10, wr_data=DEADBEEF, wr_pc=3000, write_count=1.
- Word 0x10 holds DEADBEEF; write byteen=0100 at addr 0x12, wdata=32'h5A5A5A5A -> wr_data=DE5ABEEF. Then byteen=1100 at addr 0x12, wdata=32'h12341234 -> word=1234BEEF.
- Two consecutive cycles writing 0x20=1 then 0x24=2 -> two wr_valid pulses with matching addr/data; write_count=2 more than before.
- byteen=0011 at addr 0x02 (misaligned), pc=32'h3010 -> memory unchanged, no wr_valid, fault=1, fault_addr=2, fault_pc=3010. Then write at addr BASE+DEPTH*4 -> fault_addr still 2.
- Write 0xAA to addr 0x40 while reset=1 -> word 0x40 reads 0 after reset, write_count=0, wr_valid=0.
- Same-cycle read/write to 0x30 (old 11111111, new 22222222) -> rdata=11111111 that cycle, 22222222 the next.
